// File: rtl/dbus_arbiter.sv
// rtl/dbus_arbiter.sv - shares the single data-bus port between the LSU and the page-table walker
// One transaction outstanding at a time; bus request fields are registered, responses steered to the owner.
module dbus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int PTW_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                lsu_req_i,
   input  logic                lsu_w_en_i,
   input  logic [ADDR_W-1:0]   lsu_addr_i,
   input  logic [DATA_W-1:0]   lsu_wdata_i,
   input  logic [DATA_W/8-1:0] lsu_sel_i,
   input  logic                lsu_flush_i,
   output logic                lsu_ack_o,
   output logic [DATA_W-1:0]   lsu_rdata_o,
   input  logic                ptw_req_i,
   input  logic [ADDR_W-1:0]   ptw_addr_i,
   output logic                ptw_ack_o,
   output logic [DATA_W-1:0]   ptw_rdata_o,
   output logic                dbus_req_o,
   output logic                dbus_w_en_o,
   output logic [ADDR_W-1:0]   dbus_addr_o,
   output logic [DATA_W-1:0]   dbus_wdata_o,
   output logic [DATA_W/8-1:0] dbus_sel_o,
   input  logic                dbus_ack_i,
   input  logic [DATA_W-1:0]   dbus_rdata_i,
   output logic                arb_busy_o
);

   localparam logic [3:0] CNT_MAX = 4'(PTW_MAX);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY_LSU = 2'd1,
      BUSY_PTW = 2'd2,
      DRAIN    = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] ptw_cnt;
   logic       lsu_elig;
   logic       ptw_win;
   logic       lsu_win;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // The PTW normally has priority; the counter lets a waiting LSU through after PTW_MAX walker grants.
   always_comb begin
      state_nxt   = state;
      lsu_ack_o   = 1'b0;
      ptw_ack_o   = 1'b0;
      lsu_rdata_o = '0;
      ptw_rdata_o = '0;
      lsu_elig    = lsu_req_i & ~lsu_flush_i;
      ptw_win     = 1'b0;
      lsu_win     = 1'b0;
      case (state)
         IDLE: begin
            ptw_win = ptw_req_i & ~(lsu_elig & (ptw_cnt == CNT_MAX));
            lsu_win = lsu_elig & ~ptw_win;
            if (ptw_win)      state_nxt = BUSY_PTW;
            else if (lsu_win) state_nxt = BUSY_LSU;
         end
         BUSY_LSU: begin
            if (dbus_ack_i) begin
               state_nxt = IDLE;
               // A flush coinciding with the ack squashes the response.
               if (!lsu_flush_i) begin
                  lsu_ack_o   = 1'b1;
                  lsu_rdata_o = dbus_rdata_i;
               end
            end else if (lsu_flush_i) begin
               state_nxt = DRAIN;
            end
         end
         BUSY_PTW: begin
            if (dbus_ack_i) begin
               state_nxt   = IDLE;
               ptw_ack_o   = 1'b1;
               ptw_rdata_o = dbus_rdata_i;
            end
         end
         DRAIN: begin
            if (dbus_ack_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptw_cnt      <= '0;
         dbus_req_o   <= 1'b0;
         dbus_w_en_o  <= 1'b0;
         dbus_addr_o  <= '0;
         dbus_wdata_o <= '0;
         dbus_sel_o   <= '0;
      end else if (ptw_win) begin
         dbus_req_o  <= 1'b1;
         dbus_w_en_o <= 1'b0;
         dbus_addr_o <= ptw_addr_i;
         dbus_sel_o  <= '1;
         if (lsu_req_i && (ptw_cnt != CNT_MAX)) ptw_cnt <= ptw_cnt + 4'd1;
      end else if (lsu_win) begin
         dbus_req_o   <= 1'b1;
         dbus_w_en_o  <= lsu_w_en_i;
         dbus_addr_o  <= lsu_addr_i;
         dbus_wdata_o <= lsu_wdata_i;
         dbus_sel_o   <= lsu_sel_i;
         ptw_cnt      <= '0;
      end else if ((state != IDLE) && dbus_ack_i) begin
         dbus_req_o <= 1'b0;
      end
   end

   assign arb_busy_o = (state != IDLE);

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the single data-bus (DBUS) port between the LSU and the MMU page-table walker (PTW).
- Sequences one outstanding transaction at a time and registers the bus request signals.
- Returns the ack and read data only to the owner of the transaction.
- Absorbs LSU flushes by draining an in-flight bus access, so the LSU ld_ack seen by the forward/stall unit never fires for a squashed access.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-select width is DATA_W/8.
- PTW_MAX, 4, maximum consecutive PTW grants while the LSU waits (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- lsu_req_i  in  1  LSU access request; held until lsu_ack_o.
- lsu_w_en_i  in  1  LSU write (1) / read (0).
- lsu_addr_i  in  ADDR_W  LSU address.
- lsu_wdata_i  in  DATA_W  LSU write data.
- lsu_sel_i  in  DATA_W/8  LSU byte selects.
- lsu_flush_i  in  1  LSU flush (CSR trap/new PC/WFI).
- lsu_ack_o  out  1  LSU access complete.
- lsu_rdata_o  out  DATA_W  LSU read data.
- ptw_req_i  in  1  PTW read request; held until ptw_ack_o.
- ptw_addr_i  in  ADDR_W  PTE address.
- ptw_ack_o  out  1  PTW access complete.
- ptw_rdata_o  out  DATA_W  PTE data.
- dbus_req_o  out  1  bus request, registered.
- dbus_w_en_o  out  1  bus write enable, registered.
- dbus_addr_o  out  ADDR_W  bus address, registered.
- dbus_wdata_o  out  DATA_W  bus write data, registered.
- dbus_sel_o  out  DATA_W/8  bus byte selects, registered.
- dbus_ack_i  in  1  bus ack, 1-cycle pulse.
- dbus_rdata_i  in  DATA_W  bus read data, valid with ack.
- arb_busy_o  out  1  transaction outstanding (state != IDLE).

Behaviour:
- States: IDLE, BUSY_LSU, BUSY_PTW, DRAIN.
- Reset (rst=1 at a clk edge):
  - state=IDLE, starvation counter=0.
  - All dbus_* outputs 0.
  - lsu_ack_o=ptw_ack_o=0, arb_busy_o=0.
  - Reset mid-transaction abandons it; any later dbus_ack_i in IDLE is ignored.
- IDLE arbitration, evaluated in cycle N:
  - PTW wins if ptw_req_i=1 and not (lsu eligible and cnt==PTW_MAX).
  - LSU is eligible if lsu_req_i=1 and lsu_flush_i=0.
  - Otherwise an eligible LSU wins.
  - The winner's fields are latched; dbus_req_o=1 from cycle N+1. Latency is 1 cycle from request to bus.
  - PTW grants drive dbus_w_en_o=0 and dbus_sel_o all ones; dbus_wdata_o holds its previous value.
- Starvation counter:
  - Increments on a PTW grant while lsu_req_i=1, saturating at PTW_MAX.
  - Clears on every LSU grant.
- BUSY_x:
  - dbus_* outputs stay stable until dbus_ack_i.
  - On dbus_ack_i, x_ack_o=dbus_ack_i combinationally (same cycle), x_rdata_o=dbus_rdata_i.
  - At that edge: state→IDLE and dbus_req_o→0. There is one idle bus cycle between transactions.
- Requester protocol:
  - The requester must drop its req in the cycle after its ack.
  - A req still high in IDLE is a new request.
- Flush:
  - lsu_flush_i in IDLE blocks an LSU grant that cycle.
  - lsu_flush_i in BUSY_LSU without dbus_ack_i: state→DRAIN. dbus_req_o stays high (the bus is never aborted; an issued write completes).
  - lsu_flush_i in the same cycle as dbus_ack_i in BUSY_LSU: lsu_ack_o=0 and the response is discarded. State goes directly to IDLE.
  - lsu_flush_i has no effect in BUSY_PTW.
- DRAIN:
  - lsu_ack_o=ptw_ack_o=0.
  - On dbus_ack_i: state→IDLE, dbus_req_o→0.
  - New requests are not arbitrated until IDLE.
- Read-data outputs when not acking:
  - lsu_rdata_o and ptw_rdata_o are dbus_rdata_i when the owner acks, else 0.
  - lsu_ack_o and ptw_ack_o are never both 1.
- A dbus_ack_i in IDLE is ignored; no ack is forwarded.

Test Plan:
- LSU read 0x8000_0010, bus acks with 0xDEAD_BEEF 3 cycles after dbus_req_o → dbus_req_o rises at N+1. lsu_ack_o pulses once with lsu_rdata_o=0xDEAD_BEEF, and dbus_req_o=0 the next cycle.
- PTW and LSU request in the same IDLE cycle → PTW is granted first (dbus_addr_o=ptw_addr_i, dbus_w_en_o=0). LSU is granted in the IDLE cycle after ptw_ack_o.
- PTW_MAX=4, ptw_req_i and lsu_req_i held continuously → grant order PTW×4, LSU, PTW×4, LSU; the counter clears after each LSU grant.
- LSU write to 0x100 in flight, lsu_flush_i pulses 1 cycle before ack → state=DRAIN. dbus_req_o is held until ack, lsu_ack_o stays 0 throughout, and the next grant happens only from IDLE.
- lsu_flush_i coincident with dbus_ack_i in BUSY_LSU → lsu_ack_o=0 and state=IDLE the next cycle. Separately, lsu_flush_i with a new lsu_req_i in IDLE → no grant that cycle; grant the next cycle once the flush is low.
- rst asserted in BUSY_PTW, then dbus_ack_i after reset → all outputs 0, ptw_ack_o never asserts, arb_busy_o=0.
